// File: rtl/dma_cmd_decoder_pkg.sv
// Shared encodings for the DMA command decoder.
// Op codes, beat field positions, response tag and timeout default.
package ldmx_dma_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    localparam int OP_HI   = 63;
    localparam int OP_LO   = 62;
    localparam int ADDR_HI = 49;
    localparam int ADDR_LO = 32;
    localparam int DATA_HI = 31;
    localparam int DATA_LO = 0;

    localparam int ADDR_W = ADDR_HI - ADDR_LO + 1;
    localparam int DATA_W = DATA_HI - DATA_LO + 1;

    localparam logic [1:0] RSP_TAG  = 2'b10;
    localparam logic [7:0] KEEP_ALL = 8'hFF;

    localparam int TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/dma_cmd_decoder_if.sv
// Command stream in and read-response stream out of the decoder.
// master = command source / response sink, slave = decoder.
interface dma_cmd_decoder_if;

    logic        dmaObMaster_tValid;
    logic [63:0] dmaObMaster_tData;
    logic [7:0]  dmaObMaster_tKeep;
    logic        dmaObMaster_tLast;
    logic [7:0]  dmaObMaster_tDest;
    logic        dmaObSlave_tReady;

    logic        rsp_tValid;
    logic [63:0] rsp_tData;
    logic        rsp_tLast;
    logic        rsp_tReady;

    modport master (
        output dmaObMaster_tValid,
        output dmaObMaster_tData,
        output dmaObMaster_tKeep,
        output dmaObMaster_tLast,
        output dmaObMaster_tDest,
        input  dmaObSlave_tReady,
        input  rsp_tValid,
        input  rsp_tData,
        input  rsp_tLast,
        output rsp_tReady
    );

    modport slave (
        input  dmaObMaster_tValid,
        input  dmaObMaster_tData,
        input  dmaObMaster_tKeep,
        input  dmaObMaster_tLast,
        input  dmaObMaster_tDest,
        output dmaObSlave_tReady,
        output rsp_tValid,
        output rsp_tData,
        output rsp_tLast,
        input  rsp_tReady
    );

endinterface

// File: rtl/dma_cmd_decoder.sv
// Decodes 64-bit DMA command beats into register-bus writes/reads
// with an ack timeout, returning read results as a one-beat response.
module dma_cmd_decoder
    import ldmx_dma_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                dmaClk,
    input  logic                dmaRst,
    dma_cmd_decoder_if.slave    dma,
    output logic                axi_wstr,
    output logic                axi_rstr,
    output logic [ADDR_W-1:0]   axi_waddr,
    output logic [ADDR_W-1:0]   axi_raddr,
    output logic [DATA_W-1:0]   axi_din,
    input  logic                axi_wack,
    input  logic                axi_rack,
    input  logic [DATA_W-1:0]   axi_dout,
    output logic [15:0]         cmd_count,
    output logic [15:0]         err_count
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                to_q, to_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [15:0]         cmd_q, cmd_d;
    logic [15:0]         err_q, err_d;
    logic                rdy_q;

    op_e  op;
    logic beat_ok;
    logic accept;
    logic unused_bits;

    assign op      = op_e'(dma.dmaObMaster_tData[OP_HI:OP_LO]);
    assign beat_ok = (dma.dmaObMaster_tKeep == KEEP_ALL)
                   && (dma.dmaObMaster_tDest == 8'd0);
    assign accept  = dma.dmaObMaster_tValid && dma.dmaObSlave_tReady;

    // tLast and the spare command bits carry no meaning here
    assign unused_bits = ^{dma.dmaObMaster_tLast,
                           dma.dmaObMaster_tData[OP_LO-1:ADDR_HI+1]};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        to_d    = to_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d = dma.dmaObMaster_tData[ADDR_HI:ADDR_LO];
                    cnt_d  = 8'd0;
                    if (!beat_ok) begin
                        err_d = err_q + 16'd1;
                    end else begin
                        case (op)
                            OP_WRITE: begin
                                state_d = ST_WRITE;
                                wdata_d = dma.dmaObMaster_tData[DATA_HI:DATA_LO];
                            end
                            OP_READ: begin
                                state_d = ST_READ;
                                to_d    = 1'b0;
                                rdata_d = '0;
                            end
                            OP_RSVD: err_d = err_q + 16'd1;
                            default: ;
                        endcase
                    end
                end
            end
            ST_WRITE: begin
                if (axi_wack) begin
                    state_d = ST_IDLE;
                    cmd_d   = cmd_q + 16'd1;
                end else if (cnt_q == TO_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = err_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_READ: begin
                if (axi_rack) begin
                    state_d = ST_RESP;
                    rdata_d = axi_dout;
                end else if (cnt_q == TO_LAST) begin
                    state_d = ST_RESP;
                    to_d    = 1'b1;
                    rdata_d = '0;
                    err_d   = err_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                if (dma.rsp_tReady) begin
                    state_d = ST_IDLE;
                    cmd_d   = cmd_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge dmaClk) begin
        if (dmaRst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            to_q    <= 1'b0;
            cnt_q   <= 8'd0;
            cmd_q   <= 16'd0;
            err_q   <= 16'd0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            err_q   <= err_d;
            rdy_q   <= 1'b1;
        end
    end

    assign dma.dmaObSlave_tReady = (state_q == ST_IDLE) && rdy_q;

    assign axi_wstr  = (state_q == ST_WRITE);
    assign axi_rstr  = (state_q == ST_READ);
    assign axi_waddr = axi_wstr ? addr_q : '0;
    assign axi_raddr = axi_rstr ? addr_q : '0;
    assign axi_din   = axi_wstr ? wdata_q : '0;

    assign dma.rsp_tValid = (state_q == ST_RESP);
    assign dma.rsp_tLast  = dma.rsp_tValid;
    assign dma.rsp_tData  = dma.rsp_tValid
                          ? {RSP_TAG, to_q, 11'b0, addr_q, rdata_q}
                          : 64'd0;

    assign cmd_count = cmd_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_dma_cmd_decoder.sv
// Directed and randomized checks of dma_cmd_decoder against a
// command-level model of expected bus activity and counters.
module tb_dma_cmd_decoder;
    import ldmx_dma_cmd_pkg::*;

    logic        dmaClk = 1'b0;
    logic        dmaRst = 1'b1;
    logic        axi_wstr, axi_rstr;
    logic [17:0] axi_waddr, axi_raddr;
    logic [31:0] axi_din;
    logic        axi_wack = 1'b0;
    logic        axi_rack = 1'b0;
    logic [31:0] axi_dout = 32'd0;
    logic [15:0] cmd_count, err_count;

    dma_cmd_decoder_if bus();

    dma_cmd_decoder #(.TIMEOUT_CYC(255)) dut (
        .dmaClk    (dmaClk),
        .dmaRst    (dmaRst),
        .dma       (bus.slave),
        .axi_wstr  (axi_wstr),
        .axi_rstr  (axi_rstr),
        .axi_waddr (axi_waddr),
        .axi_raddr (axi_raddr),
        .axi_din   (axi_din),
        .axi_wack  (axi_wack),
        .axi_rack  (axi_rack),
        .axi_dout  (axi_dout),
        .cmd_count (cmd_count),
        .err_count (err_count)
    );

    always #5 dmaClk = ~dmaClk;

    int total = 0;
    int bad   = 0;
    int m_cmd = 0;
    int m_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_cmd"}, 64'(cmd_count), 64'(m_cmd[15:0]));
        chk({tag, "_err"}, 64'(err_count), 64'(m_err[15:0]));
    endtask

    function automatic logic [63:0] rsp_word(input logic to,
                                             input logic [17:0] a,
                                             input logic [31:0] d);
        return {2'b10, to, 11'b0, a, d};
    endfunction

    // Present one beat, wait for acceptance, return in the first
    // cycle after the accepting edge.
    task automatic send_beat(input logic [1:0] op, input logic [7:0] keep,
                             input logic [7:0] dest, input logic [17:0] a,
                             input logic [31:0] d);
        int n = 0;
        bus.dmaObMaster_tValid = 1'b1;
        bus.dmaObMaster_tData  = {op, 12'($urandom), a, d};
        bus.dmaObMaster_tKeep  = keep;
        bus.dmaObMaster_tDest  = dest;
        bus.dmaObMaster_tLast  = 1'($urandom);
        while (!bus.dmaObSlave_tReady && n < 50) begin
            @(negedge dmaClk);
            n++;
        end
        chk("ready_wait", 64'(bus.dmaObSlave_tReady), 64'd1);
        @(negedge dmaClk);
        bus.dmaObMaster_tValid = 1'b0;
    endtask

    initial begin
        logic [63:0] exp_rsp;
        int hi;
        bus.dmaObMaster_tValid = 1'b0;
        bus.dmaObMaster_tData  = 64'd0;
        bus.dmaObMaster_tKeep  = 8'd0;
        bus.dmaObMaster_tLast  = 1'b0;
        bus.dmaObMaster_tDest  = 8'd0;
        bus.rsp_tReady         = 1'b0;

        // reset state
        repeat (3) @(negedge dmaClk);
        chk("rst_ready", 64'(bus.dmaObSlave_tReady), 64'd0);
        chk("rst_wstr", 64'(axi_wstr), 64'd0);
        chk("rst_rstr", 64'(axi_rstr), 64'd0);
        chk("rst_rspv", 64'(bus.rsp_tValid), 64'd0);
        chk_cnt("rst");
        dmaRst = 1'b0;
        chk("rel_ready0", 64'(bus.dmaObSlave_tReady), 64'd0);
        @(negedge dmaClk);
        chk("rel_ready1", 64'(bus.dmaObSlave_tReady), 64'd1);

        // write, ack in third strobe cycle
        send_beat(OP_WRITE, 8'hFF, 8'd0, 18'h00123, 32'hCAFEF00D);
        for (int i = 0; i < 3; i++) begin
            chk("wr_wstr", 64'(axi_wstr), 64'd1);
            chk("wr_addr", 64'(axi_waddr), 64'h123);
            chk("wr_din", 64'(axi_din), 64'hCAFEF00D);
            chk("wr_rstr", 64'(axi_rstr), 64'd0);
            chk("wr_ready", 64'(bus.dmaObSlave_tReady), 64'd0);
            if (i == 2) axi_wack = 1'b1;
            @(negedge dmaClk);
        end
        axi_wack = 1'b0;
        m_cmd++;
        chk("wr_done", 64'(axi_wstr), 64'd0);
        chk_cnt("wr");

        // read with immediate ack
        send_beat(OP_READ, 8'hFF, 8'd0, 18'h00042, 32'h0);
        chk("rd_rstr", 64'(axi_rstr), 64'd1);
        chk("rd_addr", 64'(axi_raddr), 64'h42);
        axi_rack = 1'b1;
        axi_dout = 32'h12345678;
        @(negedge dmaClk);
        axi_rack = 1'b0;
        chk("rd_rstr_off", 64'(axi_rstr), 64'd0);
        chk("rd_rspv", 64'(bus.rsp_tValid), 64'd1);
        chk("rd_last", 64'(bus.rsp_tLast), 64'd1);
        chk("rd_data", bus.rsp_tData, 64'h8000_0042_1234_5678);
        bus.rsp_tReady = 1'b1;
        @(negedge dmaClk);
        bus.rsp_tReady = 1'b0;
        m_cmd++;
        chk("rd_rspv_off", 64'(bus.rsp_tValid), 64'd0);
        chk_cnt("rd");

        // read timeout
        send_beat(OP_READ, 8'hFF, 8'd0, 18'h00077, 32'h0);
        hi = 0;
        while (axi_rstr && hi < 400) begin
            hi++;
            @(negedge dmaClk);
        end
        m_err++;
        chk("to_len", 64'(hi), 64'd255);
        chk("to_rspv", 64'(bus.rsp_tValid), 64'd1);
        chk("to_data", bus.rsp_tData, 64'hA000_0077_0000_0000);
        chk_cnt("to_mid");
        bus.rsp_tReady = 1'b1;
        @(negedge dmaClk);
        bus.rsp_tReady = 1'b0;
        m_cmd++;
        chk_cnt("to_end");

        // dropped beats and a NOP
        send_beat(OP_WRITE, 8'h0F, 8'd0, 18'h00001, 32'h1);
        chk("drop_keep_w", 64'(axi_wstr), 64'd0);
        send_beat(OP_READ, 8'hFF, 8'd1, 18'h00002, 32'h2);
        chk("drop_dest_r", 64'(axi_rstr), 64'd0);
        send_beat(OP_NOP, 8'hFF, 8'd0, 18'h00003, 32'h3);
        chk("nop_w", 64'(axi_wstr), 64'd0);
        chk("nop_r", 64'(axi_rstr), 64'd0);
        m_err += 2;
        chk_cnt("drop");

        // write ack in the timeout cycle
        send_beat(OP_WRITE, 8'hFF, 8'd0, 18'h3FFFF, 32'h55AA55AA);
        repeat (254) @(negedge dmaClk);
        chk("ackto_wstr", 64'(axi_wstr), 64'd1);
        axi_wack = 1'b1;
        @(negedge dmaClk);
        axi_wack = 1'b0;
        m_cmd++;
        chk("ackto_off", 64'(axi_wstr), 64'd0);
        chk_cnt("ackto");

        // stalled response, then reset inside RESP
        send_beat(OP_READ, 8'hFF, 8'd0, 18'h2BEEF, 32'h0);
        axi_rack = 1'b1;
        axi_dout = 32'hDEADBEEF;
        @(negedge dmaClk);
        axi_rack = 1'b0;
        exp_rsp = rsp_word(1'b0, 18'h2BEEF, 32'hDEADBEEF);
        for (int i = 0; i < 10; i++) begin
            chk("stall_v", 64'(bus.rsp_tValid), 64'd1);
            chk("stall_d", bus.rsp_tData, exp_rsp);
            chk("stall_rdy", 64'(bus.dmaObSlave_tReady), 64'd0);
            @(negedge dmaClk);
        end
        dmaRst = 1'b1;
        @(negedge dmaClk);
        m_cmd = 0;
        m_err = 0;
        chk("rstresp_v", 64'(bus.rsp_tValid), 64'd0);
        chk("rstresp_d", bus.rsp_tData, 64'd0);
        chk_cnt("rstresp");
        dmaRst = 1'b0;
        @(negedge dmaClk);
        chk("rstresp_rdy", 64'(bus.dmaObSlave_tReady), 64'd1);
        chk("rstresp_v2", 64'(bus.rsp_tValid), 64'd0);

        // randomized commands against the model
        for (int k = 0; k < 60; k++) begin
            logic [1:0]  op;
            logic [7:0]  keep, dest;
            logic [17:0] a;
            logic [31:0] d, dout;
            int dly, stall;
            op   = 2'($urandom_range(0, 3));
            keep = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 254))
                                               : 8'hFF;
            dest = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255))
                                               : 8'd0;
            a    = 18'($urandom);
            d    = $urandom;
            dout = $urandom;
            dly  = $urandom_range(0, 4);
            stall = $urandom_range(0, 3);
            send_beat(op, keep, dest, a, d);
            if (keep != 8'hFF || dest != 8'd0 || op == 2'b11) begin
                m_err++;
                chk("rnd_drop", 64'({axi_wstr, axi_rstr}), 64'd0);
            end else if (op == 2'b00) begin
                chk("rnd_nop", 64'({axi_wstr, axi_rstr}), 64'd0);
            end else if (op == 2'b01) begin
                for (int i = 0; i <= dly; i++) begin
                    chk("rnd_wstr", 64'({axi_wstr, axi_rstr}), 64'b10);
                    chk("rnd_wbus", 64'({axi_waddr, axi_din}), 64'({a, d}));
                    if (i == dly) axi_wack = 1'b1;
                    @(negedge dmaClk);
                end
                axi_wack = 1'b0;
                m_cmd++;
                chk("rnd_wend", 64'(axi_wstr), 64'd0);
            end else begin
                for (int i = 0; i <= dly; i++) begin
                    chk("rnd_rstr", 64'({axi_wstr, axi_rstr}), 64'b01);
                    chk("rnd_raddr", 64'(axi_raddr), 64'(a));
                    if (i == dly) begin
                        axi_rack = 1'b1;
                        axi_dout = dout;
                    end
                    @(negedge dmaClk);
                end
                axi_rack = 1'b0;
                for (int i = 0; i <= stall; i++) begin
                    chk("rnd_rspv", 64'(bus.rsp_tValid), 64'd1);
                    chk("rnd_rspd", bus.rsp_tData, rsp_word(1'b0, a, dout));
                    if (i == stall) bus.rsp_tReady = 1'b1;
                    @(negedge dmaClk);
                end
                bus.rsp_tReady = 1'b0;
                m_cmd++;
                chk("rnd_rspend", 64'(bus.rsp_tValid), 64'd0);
            end
            chk_cnt("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
